calc_sequencer: RTL and testbench
=================================

// Module: calc_sequencer
// PURPOSE
//  Keypad-to-ALU sequencer for the BCD calculator. Assembles two signed BCD operands with decimal
//  point from a key stream and latches the pending operation. Drives the combinational BCD ALU,
//  waits a fixed settle time, then registers the result for display. Supports chained operations
//  (1+2+3=) and flags divide-by-zero. Sits between the keypad decoder and the ALU/display mux.
// PARAMETERS
//  DIGIT_NUM  8  BCD digits per operand/result (operand bus = DIGIT_NUM*4 bits)
//  ALU_LAT    2  cycles operands are held stable before the ALU result is sampled (>=1)
// PORTS
//  clk            in   1            system clock, rising edge
//  rst_n          in   1            asynchronous reset, active low
//  key_valid      in   1            key_code present this cycle
//  key_ready      out  1            sequencer accepts key; key taken when key_valid & key_ready
//  key_code       in   5            0-9 digit, 10 '.', 11 '+', 12 '-', 13 '*', 14 '/', 15 '^', 16 '=', 17 CLR, 18 NEG
//  op0_sign       out  1            ALU operand0 sign (1 = negative)
//  op0            out  DIGIT_NUM*4  ALU operand0 BCD magnitude
//  op0_dp         out  3            ALU operand0 digits right of decimal point
//  op1_sign/op1/op1_dp  out  1/DIGIT_NUM*4/3  ALU operand1, same encoding as operand0
//  alu_op         out  3            0 add, 1 sub, 2 mul, 3 div, 4 pow
//  alu_result     in   DIGIT_NUM*4  ALU result BCD magnitude
//  alu_sign       in   1            ALU result sign
//  alu_dp         in   3            ALU result decimal-point position
//  disp_bcd       out  DIGIT_NUM*4  value to display
//  disp_sign      out  1            display sign
//  disp_dp        out  3            display decimal-point position
//  err            out  1            error latched (divide by zero)
// BEHAVIOUR
//  - Reset: state ENTRY0; all operand/display/dp/sign outputs 0; alu_op 0; err 0; key_ready 1.
//  - All outputs registered. key_ready = 0 only in EXEC. Keys with key_valid & ~key_ready dropped.
//  - States: ENTRY0, OPSEL, ENTRY1, EXEC, RESULT, ERROR.
//  - Digit entry (current operand: op0 in ENTRY0, op1 in ENTRY1):
//    operand <= {operand[DIGIT_NUM*4-5:0], digit}; ignored once DIGIT_NUM significant digits held.
//    Leading 0 with value 0 and no point entered: operand stays 0, digit count unchanged.
//    '.' sets point flag (second '.' ignored); each later accepted digit increments dp, saturating at 7
//    (further digits ignored). NEG toggles current sign.
//  - ENTRY0: digit/'.'/NEG edit op0; operator -> latch alu_op, go OPSEL; '=' ignored.
//  - OPSEL: operator replaces alu_op; digit or '.' -> clear op1, apply key, go ENTRY1; NEG ignored.
//  - ENTRY1: edits op1; '=' or operator -> EXEC (operator key stored as next op, chain flag set).
//  - EXEC: op0/op1/alu_op held stable ALU_LAT cycles, then sample alu_result/alu_sign/alu_dp.
//    If alu_op==3 and op1==0: no sample, err<=1, go ERROR. Else if chain: op0<=result, alu_op<=
//    stored op, go OPSEL; else result register loaded, go RESULT.
//  - RESULT: digit/'.' -> clear op0, apply key, go ENTRY0; operator -> op0<=result, go OPSEL;
//    NEG toggles result sign; '=' ignored.
//  - ERROR: only CLR accepted; all else dropped.
//  - CLR in any state except EXEC: same state as reset, next cycle. CLR in EXEC blocked (key_ready 0).
//  - Display: ENTRY0/OPSEL -> op0; ENTRY1 -> op1; EXEC -> previous value held; RESULT -> result;
//    ERROR -> disp_bcd 0, disp_sign 0, disp_dp 0, err 1.
//  - rst_n low at any time, incl. mid-EXEC: immediate return to reset values; no result sampled.
// TESTING
//  - Keys 1,2,+,3,= -> op0=0x12, op1=0x3, alu_op=0 for ALU_LAT cycles; RESULT disp_bcd=0x15.
//  - Keys 1,.,5,*,2,= -> op0=0x15 dp1, op1=0x2 dp0, alu_op=2; disp = ALU value, disp_dp=alu_dp.
//  - Keys 8,/,0,= -> ERROR, err=1, disp 0; digit 5 dropped; CLR -> ENTRY0, err=0, disp 0.
//  - Keys 1,+,2,+,3,= -> first EXEC loads op0=0x3, second EXEC result 0x6; key_ready 0 in EXEC.
//  - Nine digits 1..9 -> op0=0x12345678 (9 ignored); 0,0,7 -> op0=0x7; NEG -> op0_sign=1.
//  - Assert rst_n low mid-EXEC -> all outputs 0, state ENTRY0, key_ready 1 immediately.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-to-ALU sequencer for the BCD calculator.
// Builds two signed BCD operands from key codes, drives the external ALU and registers its result.
module calc_sequencer #(
    parameter int DIGIT_NUM = 8,
    parameter int ALU_LAT   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [4:0]             key_code,
    output logic                   op0_sign,
    output logic [DIGIT_NUM*4-1:0] op0,
    output logic [2:0]             op0_dp,
    output logic                   op1_sign,
    output logic [DIGIT_NUM*4-1:0] op1,
    output logic [2:0]             op1_dp,
    output logic [2:0]             alu_op,
    input  logic [DIGIT_NUM*4-1:0] alu_result,
    input  logic                   alu_sign,
    input  logic [2:0]             alu_dp,
    output logic [DIGIT_NUM*4-1:0] disp_bcd,
    output logic                   disp_sign,
    output logic [2:0]             disp_dp,
    output logic                   err
);
    localparam int W  = DIGIT_NUM * 4;
    localparam int NW = $clog2(DIGIT_NUM + 1);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [2:0] {
        ST_ENTRY0 = 3'd0,
        ST_OPSEL  = 3'd1,
        ST_ENTRY1 = 3'd2,
        ST_EXEC   = 3'd3,
        ST_RESULT = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // cnt and pt only matter while an operand is being typed in
    typedef struct packed {
        logic          sign;
        logic [W-1:0]  mag;
        logic [2:0]    dp;
        logic [NW-1:0] cnt;
        logic          pt;
    } opnd_t;

    localparam opnd_t OPND_ZERO = '{sign: 1'b0, mag: {W{1'b0}}, dp: 3'd0, cnt: {NW{1'b0}}, pt: 1'b0};

    state_t        state_r, state_s;
    opnd_t         op0_r, op0_s, op1_r, op1_s, res_r, res_s, disp_r, disp_s, alu_opnd_s;
    logic [2:0]    alu_op_r, alu_op_s, next_op_r, next_op_s;
    logic          chain_r, chain_s, err_r, err_s, key_ready_r, key_ready_s;
    logic [CW-1:0] exec_cnt_r, exec_cnt_s;
    logic          key_take_s, srst_s, exec_done_s, div0_s;
    logic          is_digit_s, is_point_s, is_edit_s, is_op_s, is_eq_s, is_clr_s, is_neg_s;

    function automatic opnd_t edit_opnd(input opnd_t o, input logic [4:0] k);
        opnd_t r;
        r = o;
        if (k <= 5'd9) begin
            if ((o.cnt == NW'(DIGIT_NUM)) || (o.pt && (o.dp == 3'd7)) ||
                (!o.pt && (o.mag == {W{1'b0}}) && (k == 5'd0))) begin
                r = o;
            end else begin
                r.mag = {o.mag[W-5:0], k[3:0]};
                r.cnt = o.cnt + NW'(1);
                r.dp  = o.pt ? (o.dp + 3'd1) : o.dp;
            end
        end else if (k == 5'd10) begin
            r.pt = 1'b1;
        end else if (k == 5'd18) begin
            r.sign = ~o.sign;
        end else begin
            r = o;
        end
        return r;
    endfunction

    function automatic logic [2:0] op_of_key(input logic [4:0] k);
        logic [4:0] d;
        d = k - 5'd11;
        return d[2:0];
    endfunction

    assign key_take_s  = key_valid & key_ready_r;
    assign is_digit_s  = (key_code <= 5'd9);
    assign is_point_s  = (key_code == 5'd10);
    assign is_edit_s   = is_digit_s | is_point_s;
    assign is_op_s     = (key_code >= 5'd11) && (key_code <= 5'd15);
    assign is_eq_s     = (key_code == 5'd16);
    assign is_clr_s    = (key_code == 5'd17);
    assign is_neg_s    = (key_code == 5'd18);
    assign srst_s      = key_take_s & is_clr_s;
    assign exec_done_s = (exec_cnt_r == CW'(ALU_LAT - 1));
    assign div0_s      = (alu_op_r == 3'd3) && (op1_r.mag == {W{1'b0}});
    assign alu_opnd_s  = '{sign: alu_sign, mag: alu_result, dp: alu_dp, cnt: {NW{1'b0}}, pt: 1'b0};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ENTRY0;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode from accepted keys and the EXEC settle counter
    always_comb begin
        state_s = state_r;
        if (srst_s) begin
            state_s = ST_ENTRY0;
        end else begin
            case (state_r)
                ST_ENTRY0: state_s = (key_take_s && is_op_s) ? ST_OPSEL : ST_ENTRY0;
                ST_OPSEL:  state_s = (key_take_s && is_edit_s) ? ST_ENTRY1 : ST_OPSEL;
                ST_ENTRY1: state_s = (key_take_s && (is_eq_s || is_op_s)) ? ST_EXEC : ST_ENTRY1;
                ST_EXEC: begin
                    if (!exec_done_s) begin
                        state_s = ST_EXEC;
                    end else if (div0_s) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = chain_r ? ST_OPSEL : ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (key_take_s && is_edit_s) begin
                        state_s = ST_ENTRY0;
                    end else if (key_take_s && is_op_s) begin
                        state_s = ST_OPSEL;
                    end else begin
                        state_s = ST_RESULT;
                    end
                end
                ST_ERROR:  state_s = ST_ERROR;
                default:   state_s = ST_ENTRY0;
            endcase
        end
    end

    // Next values of operands, result, display and handshake
    always_comb begin
        op0_s      = op0_r;
        op1_s      = op1_r;
        res_s      = res_r;
        alu_op_s   = alu_op_r;
        next_op_s  = next_op_r;
        chain_s    = chain_r;
        exec_cnt_s = exec_cnt_r;
        case (state_r)
            ST_ENTRY0: begin
                if (key_take_s && (is_edit_s || is_neg_s)) begin
                    op0_s = edit_opnd(op0_r, key_code);
                end else if (key_take_s && is_op_s) begin
                    alu_op_s = op_of_key(key_code);
                end else begin
                    op0_s = op0_r;
                end
            end
            ST_OPSEL: begin
                if (key_take_s && is_op_s) begin
                    alu_op_s = op_of_key(key_code);
                end else if (key_take_s && is_edit_s) begin
                    op1_s = edit_opnd(OPND_ZERO, key_code);
                end else begin
                    op1_s = op1_r;
                end
            end
            ST_ENTRY1: begin
                if (key_take_s && (is_edit_s || is_neg_s)) begin
                    op1_s = edit_opnd(op1_r, key_code);
                end else if (key_take_s && is_eq_s) begin
                    chain_s    = 1'b0;
                    exec_cnt_s = {CW{1'b0}};
                end else if (key_take_s && is_op_s) begin
                    chain_s    = 1'b1;
                    next_op_s  = op_of_key(key_code);
                    exec_cnt_s = {CW{1'b0}};
                end else begin
                    op1_s = op1_r;
                end
            end
            ST_EXEC: begin
                if (!exec_done_s) begin
                    exec_cnt_s = exec_cnt_r + CW'(1);
                end else if (div0_s) begin
                    exec_cnt_s = {CW{1'b0}};
                end else if (chain_r) begin
                    op0_s      = alu_opnd_s;
                    alu_op_s   = next_op_r;
                    exec_cnt_s = {CW{1'b0}};
                end else begin
                    res_s      = alu_opnd_s;
                    exec_cnt_s = {CW{1'b0}};
                end
            end
            ST_RESULT: begin
                if (key_take_s && is_edit_s) begin
                    op0_s = edit_opnd(OPND_ZERO, key_code);
                end else if (key_take_s && is_op_s) begin
                    op0_s    = res_r;
                    alu_op_s = op_of_key(key_code);
                end else if (key_take_s && is_neg_s) begin
                    res_s.sign = ~res_r.sign;
                end else begin
                    res_s = res_r;
                end
            end
            ST_ERROR: begin
                op0_s = op0_r;
            end
            default: begin
                op0_s = op0_r;
            end
        endcase
        case (state_s)
            ST_ENTRY0, ST_OPSEL: disp_s = op0_s;
            ST_ENTRY1:           disp_s = op1_s;
            ST_EXEC:             disp_s = disp_r;
            ST_RESULT:           disp_s = res_s;
            default:             disp_s = OPND_ZERO;
        endcase
        err_s       = (state_s == ST_ERROR);
        key_ready_s = (state_s != ST_EXEC);
    end

    // Datapath and output registers; CLR acts as a synchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op0_r       <= OPND_ZERO;
            op1_r       <= OPND_ZERO;
            res_r       <= OPND_ZERO;
            disp_r      <= OPND_ZERO;
            alu_op_r    <= 3'd0;
            next_op_r   <= 3'd0;
            chain_r     <= 1'b0;
            exec_cnt_r  <= {CW{1'b0}};
            err_r       <= 1'b0;
            key_ready_r <= 1'b1;
        end else if (srst_s) begin
            op0_r       <= OPND_ZERO;
            op1_r       <= OPND_ZERO;
            res_r       <= OPND_ZERO;
            disp_r      <= OPND_ZERO;
            alu_op_r    <= 3'd0;
            next_op_r   <= 3'd0;
            chain_r     <= 1'b0;
            exec_cnt_r  <= {CW{1'b0}};
            err_r       <= 1'b0;
            key_ready_r <= 1'b1;
        end else begin
            op0_r       <= op0_s;
            op1_r       <= op1_s;
            res_r       <= res_s;
            disp_r      <= disp_s;
            alu_op_r    <= alu_op_s;
            next_op_r   <= next_op_s;
            chain_r     <= chain_s;
            exec_cnt_r  <= exec_cnt_s;
            err_r       <= err_s;
            key_ready_r <= key_ready_s;
        end
    end

    assign key_ready = key_ready_r;
    assign op0_sign  = op0_r.sign;
    assign op0       = op0_r.mag;
    assign op0_dp    = op0_r.dp;
    assign op1_sign  = op1_r.sign;
    assign op1       = op1_r.mag;
    assign op1_dp    = op1_r.dp;
    assign alu_op    = alu_op_r;
    assign disp_bcd  = disp_r.mag;
    assign disp_sign = disp_r.sign;
    assign disp_dp   = disp_r.dp;
    assign err       = err_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: directed scenarios plus random key streams against
// a decimal-arithmetic reference model and a behavioural ALU stub.
module tb_calc_sequencer;
    localparam int DN  = 8;
    localparam int LAT = 2;
    localparam int W   = DN * 4;
    localparam longint MODV = 64'd100000000;
    localparam int M_E0 = 0, M_OS = 1, M_E1 = 2, M_EX = 3, M_RES = 4, M_ERR = 5;

    logic         clk, rst_n, key_valid, key_ready;
    logic [4:0]   key_code;
    logic         op0_sign, op1_sign, alu_sign, disp_sign, err;
    logic [W-1:0] op0, op1, alu_result, disp_bcd;
    logic [2:0]   op0_dp, op1_dp, alu_op, alu_dp, disp_dp;
    logic [112:0] obs_w;

    int n_vec = 0;
    int n_bad = 0;

    int     m_mode, m_op, m_next_op, r_dp, d_dp;
    longint m_val[2];
    int     m_cnt[2];
    int     m_dp[2];
    bit     m_pt[2];
    bit     m_sign[2];
    bit     m_chain, r_sign, d_sign, m_err;
    longint r_val, d_val;

    calc_sequencer #(.DIGIT_NUM(DN), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key_code(key_code), .op0_sign(op0_sign), .op0(op0), .op0_dp(op0_dp),
        .op1_sign(op1_sign), .op1(op1), .op1_dp(op1_dp), .alu_op(alu_op),
        .alu_result(alu_result), .alu_sign(alu_sign), .alu_dp(alu_dp),
        .disp_bcd(disp_bcd), .disp_sign(disp_sign), .disp_dp(disp_dp), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_w = {op0_sign, op0, op0_dp, op1_sign, op1, op1_dp, alu_op,
                    disp_sign, disp_bcd, disp_dp, err, key_ready};

    function automatic longint bcd2int(input logic [W-1:0] b);
        longint v = 0;
        for (int i = DN - 1; i >= 0; i--) v = v * 10 + longint'(b[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r;
        longint t = v;
        for (int i = 0; i < DN; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // ALU stub: plain decimal arithmetic on the operand magnitudes
    function automatic longint alu_mag(input int op, input longint a, input longint b);
        case (op)
            0: return (a + b) % MODV;
            1: return (a >= b) ? a - b : b - a;
            2: return (a * b) % MODV;
            3: return (b != 0) ? a / b : 64'd0;
            default: return (a * a) % MODV;
        endcase
    endfunction

    function automatic bit alu_sgn(input int op, input bit sa, input bit sb, input longint a, input longint b);
        if (op == 1) return a < b;
        if (op == 2 || op == 3) return sa ^ sb;
        return sa;
    endfunction

    function automatic logic [2:0] alu_dpf(input int op, input int da, input int db);
        if (op == 2) return 3'(da + db);
        return 3'((da > db) ? da : db);
    endfunction

    always_comb begin
        alu_result = int2bcd(alu_mag(int'(alu_op), bcd2int(op0), bcd2int(op1)));
        alu_sign   = alu_sgn(int'(alu_op), op0_sign, op1_sign, bcd2int(op0), bcd2int(op1));
        alu_dp     = alu_dpf(int'(alu_op), int'(op0_dp), int'(op1_dp));
    end

    task automatic model_clear(input int i);
        m_val[i] = 0; m_cnt[i] = 0; m_dp[i] = 0; m_pt[i] = 0; m_sign[i] = 0;
    endtask

    task automatic model_reset();
        model_clear(0); model_clear(1);
        m_mode = M_E0; m_op = 0; m_next_op = 0; m_chain = 0; m_err = 0;
        r_val = 0; r_sign = 0; r_dp = 0; d_val = 0; d_sign = 0; d_dp = 0;
    endtask

    task automatic model_edit(input int i, input int k);
        if (k <= 9) begin
            if (m_cnt[i] == DN) begin end
            else if (m_pt[i] && m_dp[i] == 7) begin end
            else if (!m_pt[i] && m_val[i] == 0 && k == 0) begin end
            else begin
                m_val[i] = m_val[i] * 10 + k;
                m_cnt[i]++;
                if (m_pt[i]) m_dp[i]++;
            end
        end else if (k == 10) m_pt[i] = 1;
        else if (k == 18) m_sign[i] = ~m_sign[i];
    endtask

    task automatic model_key(input int k, output bit ex);
        bit is_op;
        ex = 0;
        is_op = (k >= 11 && k <= 15);
        if (k == 17) model_reset();
        else case (m_mode)
            M_E0: begin
                if (k <= 10 || k == 18) model_edit(0, k);
                else if (is_op) begin m_op = k - 11; m_mode = M_OS; end
            end
            M_OS: begin
                if (is_op) m_op = k - 11;
                else if (k <= 10) begin model_clear(1); model_edit(1, k); m_mode = M_E1; end
            end
            M_E1: begin
                if (k <= 10 || k == 18) model_edit(1, k);
                else if (k == 16) begin m_chain = 0; ex = 1; m_mode = M_EX; end
                else if (is_op) begin m_chain = 1; m_next_op = k - 11; ex = 1; m_mode = M_EX; end
            end
            M_RES: begin
                if (k <= 10) begin model_clear(0); model_edit(0, k); m_mode = M_E0; end
                else if (is_op) begin
                    m_val[0] = r_val; m_sign[0] = r_sign; m_dp[0] = r_dp; m_op = k - 11; m_mode = M_OS;
                end else if (k == 18) r_sign = ~r_sign;
            end
            default: begin end
        endcase
    endtask

    task automatic model_exec();
        longint a, b, rv;
        bit rs;
        int rd;
        a = m_val[0]; b = m_val[1];
        if (m_op == 3 && b == 0) begin
            m_mode = M_ERR; m_err = 1;
        end else begin
            rv = alu_mag(m_op, a, b);
            rs = alu_sgn(m_op, m_sign[0], m_sign[1], a, b);
            rd = int'(alu_dpf(m_op, m_dp[0], m_dp[1]));
            if (m_chain) begin
                m_val[0] = rv; m_sign[0] = rs; m_dp[0] = rd; m_op = m_next_op; m_mode = M_OS;
            end else begin
                r_val = rv; r_sign = rs; r_dp = rd; m_mode = M_RES;
            end
        end
    endtask

    task automatic model_disp();
        case (m_mode)
            M_E0, M_OS: begin d_val = m_val[0]; d_sign = m_sign[0]; d_dp = m_dp[0]; end
            M_E1:       begin d_val = m_val[1]; d_sign = m_sign[1]; d_dp = m_dp[1]; end
            M_RES:      begin d_val = r_val;    d_sign = r_sign;    d_dp = r_dp;    end
            default:    begin d_val = 0;        d_sign = 0;         d_dp = 0;       end
        endcase
    endtask

    // Press one key; if it starts a calculation, check the busy window and then resolve it
    task automatic apply_key(input int k);
        bit ex;
        logic [112:0] exp_v;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'(k);
        @(negedge clk);
        key_valid = 1'b0;
        model_key(k, ex);
        if (ex) begin
            for (int i = 0; i < LAT; i++) begin
                n_vec++;
                if ({key_ready, op0_sign, op0, op1_sign, op1, alu_op, disp_bcd, disp_sign, disp_dp} !==
                    {1'b0, m_sign[0], int2bcd(m_val[0]), m_sign[1], int2bcd(m_val[1]), 3'(m_op),
                     int2bcd(d_val), d_sign, 3'(d_dp)}) begin
                    n_bad++;
                    $display("FAIL exec_hold cycle %0d: got rdy=%b op0=%h op1=%h op=%0d disp=%h, expected rdy=0 op0=%h op1=%h op=%0d disp=%h",
                             i, key_ready, op0, op1, alu_op, disp_bcd, int2bcd(m_val[0]), int2bcd(m_val[1]), m_op, int2bcd(d_val));
                end
                key_valid = 1'b1;
                key_code  = 5'($urandom_range(0, 18));
                @(negedge clk);
            end
            key_valid = 1'b0;
            model_exec();
        end
        model_disp();
        exp_v = {m_sign[0], int2bcd(m_val[0]), 3'(m_dp[0]), m_sign[1], int2bcd(m_val[1]), 3'(m_dp[1]),
                 3'(m_op), d_sign, int2bcd(d_val), 3'(d_dp), m_err, 1'b1};
        n_vec++;
        if (obs_w !== exp_v) begin
            n_bad++;
            $display("FAIL key_%0d: got %h expected %h", k, obs_w, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_valid = 1'b0; key_code = 5'd0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (obs_w !== 113'd1) begin n_bad++; $display("FAIL reset: got %h expected %h", obs_w, 113'd1); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_add();
        apply_key(1); apply_key(2); apply_key(11);
        n_vec++;
        if (op0 !== 32'h12) begin n_bad++; $display("FAIL add_op0: got %h expected 12", op0); end
        apply_key(3); apply_key(16);
        n_vec++;
        if (disp_bcd !== 32'h15) begin n_bad++; $display("FAIL add_result: got %h expected 15", disp_bcd); end
    endtask

    task automatic test_mul_dp();
        apply_key(17); apply_key(1); apply_key(10); apply_key(5); apply_key(13);
        n_vec++;
        if ({op0, op0_dp} !== {32'h15, 3'd1}) begin n_bad++; $display("FAIL mul_op0: got %h dp %0d expected 15 dp 1", op0, op0_dp); end
        apply_key(2); apply_key(16);
        n_vec++;
        if ({disp_bcd, disp_dp} !== {32'h30, 3'd1}) begin n_bad++; $display("FAIL mul_result: got %h dp %0d expected 30 dp 1", disp_bcd, disp_dp); end
    endtask

    task automatic test_div0();
        apply_key(17); apply_key(8); apply_key(14); apply_key(0); apply_key(16);
        n_vec++;
        if ({err, disp_bcd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL div0_err: got err=%b disp=%h expected err=1 disp=0", err, disp_bcd); end
        apply_key(5);
        n_vec++;
        if ({err, disp_bcd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL div0_drop: got err=%b disp=%h expected err=1 disp=0", err, disp_bcd); end
        apply_key(17);
        n_vec++;
        if ({err, disp_bcd} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL div0_clr: got err=%b disp=%h expected err=0 disp=0", err, disp_bcd); end
    endtask

    task automatic test_chain();
        apply_key(17); apply_key(1); apply_key(11); apply_key(2); apply_key(11);
        n_vec++;
        if ({op0, alu_op} !== {32'h3, 3'd0}) begin n_bad++; $display("FAIL chain_op0: got %h op %0d expected 3 op 0", op0, alu_op); end
        apply_key(3); apply_key(16);
        n_vec++;
        if (disp_bcd !== 32'h6) begin n_bad++; $display("FAIL chain_result: got %h expected 6", disp_bcd); end
    endtask

    task automatic test_digits();
        apply_key(17);
        for (int d = 1; d <= 9; d++) apply_key(d);
        n_vec++;
        if (op0 !== 32'h12345678) begin n_bad++; $display("FAIL digit_limit: got %h expected 12345678", op0); end
        apply_key(17); apply_key(0); apply_key(0); apply_key(7);
        n_vec++;
        if (op0 !== 32'h7) begin n_bad++; $display("FAIL leading_zero: got %h expected 7", op0); end
        apply_key(18);
        n_vec++;
        if (op0_sign !== 1'b1) begin n_bad++; $display("FAIL neg: got %b expected 1", op0_sign); end
        apply_key(17); apply_key(10);
        for (int d = 1; d <= 8; d++) apply_key(d);
        apply_key(10);
        n_vec++;
        if ({op0, op0_dp} !== {32'h1234567, 3'd7}) begin n_bad++; $display("FAIL dp_sat: got %h dp %0d expected 1234567 dp 7", op0, op0_dp); end
    endtask

    task automatic test_reset_mid_exec();
        apply_key(17); apply_key(1); apply_key(11); apply_key(3);
        @(negedge clk);
        key_valid = 1'b1; key_code = 5'd16;
        @(negedge clk);
        key_valid = 1'b0;
        n_vec++;
        if (key_ready !== 1'b0) begin n_bad++; $display("FAIL exec_busy: got %b expected 0", key_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs_w !== 113'd1) begin n_bad++; $display("FAIL rst_mid_exec: got %h expected %h", obs_w, 113'd1); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (LAT + 1) @(negedge clk);
        n_vec++;
        if (obs_w !== 113'd1) begin n_bad++; $display("FAIL rst_no_sample: got %h expected %h", obs_w, 113'd1); end
    endtask

    task automatic test_random();
        int r, k;
        apply_key(17);
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50) k = int'($urandom_range(0, 9));
            else if (r < 57) k = 10;
            else if (r < 73) k = int'($urandom_range(11, 15));
            else if (r < 85) k = 16;
            else if (r < 92) k = 18;
            else k = 17;
            apply_key(k);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add();
        test_mul_dp();
        test_div0();
        test_chain();
        test_digits();
        test_reset_mid_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
